// File: rtl/vx_dispatch_pkg.sv
// Shared types for the lane dispatcher: full-warp issue packet, lane-sliced execute packet,
// and the batch-count / batch-index width derivations.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef INST_ALU_BITS
`define INST_ALU_BITS 4
`endif
`ifndef INST_MOD_BITS
`define INST_MOD_BITS 3
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef LOG2UP
`define LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif
`ifndef NT_WIDTH
`define NT_WIDTH `LOG2UP(`NUM_THREADS)
`endif

package vx_dispatch_pkg;

    localparam int DISP_THREADS   = `NUM_THREADS;
    localparam int DISP_LANES     = 2;
    localparam int DISP_BATCH_CNT = DISP_THREADS / DISP_LANES;
    localparam int DISP_PID_WIDTH = `LOG2UP(DISP_BATCH_CNT);

    typedef logic [`UUID_WIDTH-1:0]    uuid_t;
    typedef logic [`NW_WIDTH-1:0]      wid_t;
    typedef logic [`INST_ALU_BITS-1:0] op_type_t;
    typedef logic [`INST_MOD_BITS-1:0] op_mod_t;
    typedef logic [`XLEN-1:0]          word_t;
    typedef logic [`NR_BITS-1:0]       reg_t;
    typedef logic [`NT_WIDTH-1:0]      tid_t;
    typedef logic [DISP_PID_WIDTH-1:0] pid_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } disp_state_e;

    typedef struct packed {
        uuid_t                     uuid;
        wid_t                      wid;
        logic [DISP_THREADS-1:0]   tmask;
        op_type_t                  op_type;
        op_mod_t                   op_mod;
        logic                      use_pc;
        logic                      use_imm;
        word_t                     pc;
        word_t                     imm;
        reg_t                      rd;
        logic                      wb;
        tid_t                      tid;
        word_t [DISP_THREADS-1:0]  rs1_data;
        word_t [DISP_THREADS-1:0]  rs2_data;
        word_t [DISP_THREADS-1:0]  rs3_data;
    } issue_data_t;

    typedef struct packed {
        uuid_t                     uuid;
        wid_t                      wid;
        logic [DISP_LANES-1:0]     tmask;
        op_type_t                  op_type;
        op_mod_t                   op_mod;
        logic                      use_pc;
        logic                      use_imm;
        word_t                     pc;
        word_t                     imm;
        reg_t                      rd;
        logic                      wb;
        tid_t                      tid;
        word_t [DISP_LANES-1:0]    rs1_data;
        word_t [DISP_LANES-1:0]    rs2_data;
        word_t [DISP_LANES-1:0]    rs3_data;
        pid_t                      pid;
        logic                      sop;
        logic                      eop;
    } exec_data_t;

endpackage

// File: rtl/vx_lane_dispatch_if.sv
// Issue-side and execute-side handshakes of the lane dispatcher; slave is the dispatcher view.
interface vx_lane_dispatch_if;
    import vx_dispatch_pkg::*;

    logic        in_valid;
    issue_data_t in_data;
    logic        in_ready;
    logic        out_valid;
    exec_data_t  out_data;
    logic        out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/vx_lane_dispatch_penc.sv
// Lowest-set-bit priority encoder; valid_out flags a non-zero input.
module VX_priority_encoder #(
    parameter int N  = 2,
    parameter int LN = `LOG2UP(N)
) (
    input  logic [N-1:0]  data_in,
    output logic [LN-1:0] index,
    output logic          valid_out
);
    always_comb begin
        index     = '0;
        valid_out = |data_in;
        for (int i = N - 1; i >= 0; i--) begin
            if (data_in[i]) index = LN'(i);
        end
    end
endmodule

// File: rtl/vx_lane_dispatch.sv
// Splits one full-warp issue packet into NUM_LANES-wide execute packets, skipping empty
// batches, with a registered output and no bubble between consecutive packets.
module vx_lane_dispatch
    import vx_dispatch_pkg::*;
#(
    parameter int NUM_THREADS = `NUM_THREADS,
    parameter int NUM_LANES   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    vx_lane_dispatch_if.slave bus
);
    localparam int BATCH_CNT = NUM_THREADS / NUM_LANES;
    localparam int PID_WIDTH = `LOG2UP(BATCH_CNT);

    if ((NUM_THREADS % NUM_LANES) != 0) begin : g_bad_ratio
        $error("NUM_THREADS must be a multiple of NUM_LANES");
    end
    if (NUM_THREADS != DISP_THREADS || NUM_LANES != DISP_LANES) begin : g_bad_pkg
        $error("vx_dispatch_pkg packet types do not match NUM_THREADS/NUM_LANES");
    end

    function automatic logic [BATCH_CNT-1:0] onehot(logic [PID_WIDTH-1:0] p);
        logic [BATCH_CNT-1:0] oh;
        oh    = '0;
        oh[p] = 1'b1;
        return oh;
    endfunction

    function automatic exec_data_t lane_slice(issue_data_t d, logic [PID_WIDTH-1:0] p);
        exec_data_t e;
        e         = '0;
        e.uuid    = d.uuid;
        e.wid     = d.wid;
        e.op_type = d.op_type;
        e.op_mod  = d.op_mod;
        e.use_pc  = d.use_pc;
        e.use_imm = d.use_imm;
        e.pc      = d.pc;
        e.imm     = d.imm;
        e.rd      = d.rd;
        e.wb      = d.wb;
        e.tid     = d.tid;
        for (int l = 0; l < NUM_LANES; l++) begin
            e.tmask[l]    = d.tmask[int'(p) * NUM_LANES + l];
            e.rs1_data[l] = d.rs1_data[int'(p) * NUM_LANES + l];
            e.rs2_data[l] = d.rs2_data[int'(p) * NUM_LANES + l];
            e.rs3_data[l] = d.rs3_data[int'(p) * NUM_LANES + l];
        end
        return e;
    endfunction

    disp_state_e          state_q, state_d;
    logic [BATCH_CNT-1:0] pend_q, pend_d, pend_in, src_pend;
    logic [PID_WIDTH-1:0] pid_q, pid_d, pid_nxt;
    logic                 sop_q, sop_d, eop_q, eop_d;
    logic                 pid_found, accept, fire, load;
    issue_data_t          data_q, data_d, src_data;
    exec_data_t           lane_q, lane_d;

    assign fire         = (state_q == ST_SEND) && bus.out_ready;
    assign bus.in_ready = (state_q == ST_IDLE) || (bus.out_ready && eop_q);
    assign accept       = bus.in_valid && bus.in_ready;
    assign load         = accept || (fire && !eop_q);
    assign bus.out_valid = (state_q == ST_SEND);

    // An all-zero mask still produces one packet so the instruction retires.
    always_comb begin
        for (int b = 0; b < BATCH_CNT; b++) begin
            pend_in[b] = 1'b0;
            for (int l = 0; l < NUM_LANES; l++) begin
                pend_in[b] = pend_in[b] | bus.in_data.tmask[b * NUM_LANES + l];
            end
        end
        if (pend_in == '0) pend_in = BATCH_CNT'(1);
        src_pend = accept ? pend_in : (pend_q & ~onehot(pid_q));
        src_data = accept ? bus.in_data : data_q;
    end

    VX_priority_encoder #(
        .N  (BATCH_CNT),
        .LN (PID_WIDTH)
    ) u_pid_enc (
        .data_in   (src_pend),
        .index     (pid_nxt),
        .valid_out (pid_found)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        pid_d   = pid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        data_d  = data_q;
        lane_d  = lane_q;
        if (load) begin
            state_d = ST_SEND;
            pend_d  = src_pend;
            pid_d   = pid_found ? pid_nxt : '0;
            sop_d   = accept;
            eop_d   = ((src_pend & ~onehot(pid_d)) == '0);
            data_d  = src_data;
            lane_d  = lane_slice(src_data, pid_d);
        end else if (fire) begin
            state_d = ST_IDLE;
            pend_d  = '0;
        end
    end

    always_comb begin
        bus.out_data     = lane_q;
        bus.out_data.pid = pid_t'(pid_q);
        bus.out_data.sop = sop_q;
        bus.out_data.eop = eop_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            pid_q   <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            pid_q   <= pid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
        lane_q <= lane_d;
    end
endmodule

// File: tb/tb_vx_lane_dispatch.sv
// Bench for vx_lane_dispatch: mask table, directed multi-cycle sequences and random traffic
// checked against a packet-level scoreboard.
module tb_vx_lane_dispatch;
    import vx_dispatch_pkg::*;

    localparam int NT = DISP_THREADS;
    localparam int NL = DISP_LANES;
    localparam int BC = DISP_BATCH_CNT;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    vx_lane_dispatch_if bus ();

    vx_lane_dispatch #(
        .NUM_THREADS (NT),
        .NUM_LANES   (NL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int         total = 0;
    int         bad = 0;
    bit         mon_en = 1'b0;
    exec_data_t exp_q[$];
    exec_data_t got_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic issue_data_t rand_pkt(input logic [NT-1:0] tm);
        issue_data_t d;
        d.uuid    = uuid_t'({$urandom(), $urandom()});
        d.wid     = wid_t'($urandom());
        d.tmask   = tm;
        d.op_type = op_type_t'($urandom());
        d.op_mod  = op_mod_t'($urandom());
        d.use_pc  = 1'($urandom());
        d.use_imm = 1'($urandom());
        d.pc      = $urandom();
        d.imm     = $urandom();
        d.rd      = reg_t'($urandom());
        d.wb      = 1'($urandom());
        d.tid     = tid_t'($urandom());
        for (int t = 0; t < NT; t++) begin
            d.rs1_data[t] = $urandom();
            d.rs2_data[t] = $urandom();
            d.rs3_data[t] = $urandom();
        end
        return d;
    endfunction

    // Reference: list the batches that hold any active thread (batch 0 if none), in order.
    task automatic model_push(input issue_data_t d);
        int         bl[$];
        exec_data_t e;
        bit         any;
        for (int b = 0; b < BC; b++) begin
            any = 1'b0;
            for (int l = 0; l < NL; l++) if (d.tmask[b * NL + l]) any = 1'b1;
            if (any) bl.push_back(b);
        end
        if (bl.size() == 0) bl.push_back(0);
        for (int k = 0; k < bl.size(); k++) begin
            e         = '0;
            e.uuid    = d.uuid;    e.wid     = d.wid;
            e.op_type = d.op_type; e.op_mod  = d.op_mod;
            e.use_pc  = d.use_pc;  e.use_imm = d.use_imm;
            e.pc      = d.pc;      e.imm     = d.imm;
            e.rd      = d.rd;      e.wb      = d.wb;
            e.tid     = d.tid;
            for (int l = 0; l < NL; l++) begin
                e.tmask[l]    = d.tmask[bl[k] * NL + l];
                e.rs1_data[l] = d.rs1_data[bl[k] * NL + l];
                e.rs2_data[l] = d.rs2_data[bl[k] * NL + l];
                e.rs3_data[l] = d.rs3_data[bl[k] * NL + l];
            end
            e.pid = pid_t'(bl[k]);
            e.sop = (k == 0);
            e.eop = (k == bl.size() - 1);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (!reset_n) begin
                exp_q.delete();
            end else begin
                chk("mon_out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
                chk("mon_in_ready", 64'(bus.in_ready),
                    64'(exp_q.size() == 0 || (bus.out_ready && exp_q[0].eop)));
                if (exp_q.size() != 0 && bus.out_valid) begin
                    total++;
                    if (bus.out_data !== exp_q[0]) begin
                        bad++;
                        $display("FAIL mon_out_data: got %h expected %h", bus.out_data, exp_q[0]);
                    end
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
                if (bus.in_valid && bus.in_ready) model_push(bus.in_data);
            end
        end
    end

    task automatic send(input issue_data_t d);
        bit got = 1'b0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            got = bus.in_ready;
        end
        if (!got) chk("send_timeout", 64'(got), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic collect();
        got_q.delete();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back(bus.out_data);
                if (bus.out_data.eop) return;
            end
        end
        chk("collect_timeout", 64'(0), 64'(1));
    endtask

    typedef struct {
        logic [NT-1:0] tm;
        int            n;
        int            pid_f;
        logic [NL-1:0] tm_f;
        int            pid_l;
        logic [NL-1:0] tm_l;
    } vec_t;

    vec_t        vt[7];
    issue_data_t d;
    exec_data_t  held;
    logic        v_log[4];
    int          p_log[4];
    logic        r_log[4];
    bit          acc;

    initial begin
        vt[0] = '{4'b1111, 2, 0, 2'b11, 1, 2'b11};
        vt[1] = '{4'b1100, 1, 1, 2'b11, 1, 2'b11};
        vt[2] = '{4'b0000, 1, 0, 2'b00, 0, 2'b00};
        vt[3] = '{4'b0011, 1, 0, 2'b11, 0, 2'b11};
        vt[4] = '{4'b0110, 2, 0, 2'b10, 1, 2'b01};
        vt[5] = '{4'b1000, 1, 1, 2'b10, 1, 2'b10};
        vt[6] = '{4'b0101, 2, 0, 2'b01, 1, 2'b01};

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        for (int i = 0; i < 7; i++) begin
            d = rand_pkt(vt[i].tm);
            if (i == 0) for (int t = 0; t < NT; t++) d.rs1_data[t] = word_t'(t + 1);
            bus.out_ready = 1'b1;
            send(d);
            collect();
            chk($sformatf("v%0d_npkt", i), 64'(got_q.size()), 64'(vt[i].n));
            if (got_q.size() > 0) begin
                chk($sformatf("v%0d_pid_first", i), 64'(got_q[0].pid), 64'(vt[i].pid_f));
                chk($sformatf("v%0d_tmask_first", i), 64'(got_q[0].tmask), 64'(vt[i].tm_f));
                chk($sformatf("v%0d_sop_first", i), 64'(got_q[0].sop), 64'(1));
                chk($sformatf("v%0d_pid_last", i), 64'(got_q[$].pid), 64'(vt[i].pid_l));
                chk($sformatf("v%0d_tmask_last", i), 64'(got_q[$].tmask), 64'(vt[i].tm_l));
                chk($sformatf("v%0d_eop_last", i), 64'(got_q[$].eop), 64'(1));
            end
            if (i == 0 && got_q.size() == 2) begin
                chk("full_rs1_p0", {got_q[0].rs1_data[1], got_q[0].rs1_data[0]}, {32'd2, 32'd1});
                chk("full_rs1_p1", {got_q[1].rs1_data[1], got_q[1].rs1_data[0]}, {32'd4, 32'd3});
                chk("full_eop_p0", 64'(got_q[0].eop), 64'(0));
                chk("full_sop_p1", 64'(got_q[1].sop), 64'(0));
            end
            @(posedge clk);
            #1;
        end

        // Back-to-back full masks with in_valid held: four packets, no gap.
        bus.out_ready = 1'b1;
        send(rand_pkt(4'b1111));
        bus.in_data  = rand_pkt(4'b1111);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            v_log[k] = bus.out_valid;
            p_log[k] = int'(bus.out_data.pid);
            r_log[k] = bus.in_ready;
            if (bus.in_valid && bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("b2b_valid%0d", k), 64'(v_log[k]), 64'(1));
            chk($sformatf("b2b_pid%0d", k), 64'(p_log[k]), 64'(k % 2));
            chk($sformatf("b2b_in_ready%0d", k), 64'(r_log[k]), 64'(k % 2));
        end
        @(negedge clk);
        chk("b2b_idle_after", 64'(bus.out_valid), 64'(0));
        @(posedge clk);
        #1;

        // Backpressure on pid0 for three cycles.
        bus.out_ready = 1'b0;
        send(rand_pkt(4'b1111));
        @(negedge clk);
        held = bus.out_data;
        chk("bp_pid0", 64'(bus.out_data.pid), 64'(0));
        chk("bp_in_ready0", 64'(bus.in_ready), 64'(0));
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", k), 64'(bus.out_data === held), 64'(1));
            chk($sformatf("bp_in_ready%0d", k), 64'(bus.in_ready), 64'(0));
            chk($sformatf("bp_valid%0d", k), 64'(bus.out_valid), 64'(1));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_pid", 64'(bus.out_data.pid), 64'(0));
        @(negedge clk);
        chk("bp_next_valid", 64'(bus.out_valid), 64'(1));
        chk("bp_next_pid", 64'(bus.out_data.pid), 64'(1));
        chk("bp_next_eop", 64'(bus.out_data.eop), 64'(1));
        @(posedge clk);
        #1;

        // Reset while pid0 is pending drops the rest of the packet.
        bus.out_ready = 1'b0;
        send(rand_pkt(4'b1111));
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rmid_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rmid_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rmid_quiet%0d", k), 64'(bus.out_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        send(rand_pkt(4'b0011));
        collect();
        chk("rmid_npkt", 64'(got_q.size()), 64'(1));
        if (got_q.size() > 0) begin
            chk("rmid_sop", 64'(got_q[0].sop), 64'(1));
            chk("rmid_pid", 64'(got_q[0].pid), 64'(0));
        end
        @(posedge clk);
        #1;

        // Random traffic against the scoreboard.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc || !bus.in_valid) begin
                bus.in_valid = ($urandom_range(2) != 0);
                bus.in_data  = rand_pkt(NT'($urandom()));
            end
            bus.out_ready = ($urandom_range(3) != 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
